// File: rtl/seg_scan_driver_pkg.sv
// Seven-segment pattern constants and segment bit order for the scan driver.
// Segment vectors are active-low, with segment a in bit 6 down to segment g in bit 0.
package seg_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    localparam seg_t SEG_0   = 7'b0000001;
    localparam seg_t SEG_1   = 7'b1001111;
    localparam seg_t SEG_2   = 7'b0010010;
    localparam seg_t SEG_3   = 7'b0000110;
    localparam seg_t SEG_4   = 7'b1001100;
    localparam seg_t SEG_5   = 7'b0100100;
    localparam seg_t SEG_6   = 7'b0100000;
    localparam seg_t SEG_7   = 7'b0001101;
    localparam seg_t SEG_8   = 7'b0000000;
    localparam seg_t SEG_9   = 7'b0000100;
    localparam seg_t SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the scan driver: digit inputs and segment/anode outputs.
// The blink_i signal exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_driver_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) ();

    logic [4*NUM_DIGITS-1:0] digits_i;
    logic                    blank_lz_i;
`ifdef SEG_SCAN_BLINK_EN
    logic                    blink_i;
`endif
    seg_t                    seg_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;

`ifdef SEG_SCAN_BLINK_EN
    modport master (output digits_i, blank_lz_i, blink_i, input seg_o, an_o, frame_o);
    modport slave  (input digits_i, blank_lz_i, blink_i, output seg_o, an_o, frame_o);
`else
    modport master (output digits_i, blank_lz_i, input seg_o, an_o, frame_o);
    modport slave  (input digits_i, blank_lz_i, output seg_o, an_o, frame_o);
`endif

endinterface

// File: rtl/seg_scan_driver_decoder.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes go dark.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed BCD seven-segment scan driver with frame-aligned digit capture and
// leading-zero blanking; whole-display blinking is added when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus
);

    localparam int PSC_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIG_W = 4 * NUM_DIGITS;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PSC_W-1:0]      psc_q, psc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIG_W-1:0]      shadow_q, shadow_d;
    seg_t                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  psc_tc;
    logic                  frame_wrap;
    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  hide;

    always_comb begin
        psc_tc     = (psc_q == PSC_LAST);
        frame_wrap = psc_tc && (idx_q == IDX_LAST);
        psc_d      = psc_tc ? '0 : psc_q + 1'b1;
        idx_d      = idx_q;
        if (psc_tc) begin
            idx_d = frame_wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d = frame_wrap ? bus.digits_i : shadow_q;
        frame_d  = frame_wrap;
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        cur_digit  = 4'd0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (shadow_q[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_above && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_digit = shadow_q[4*k +: 4];
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = 10;

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    // phase_q = 1 marks the hidden half of the blink period.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_wrap) begin
            if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign hide = bus.blink_i && phase_q;
`else
    assign hide = 1'b0;
`endif

    seg_decoder u_dec (
        .bcd_i (cur_digit),
        .seg_o (seg_d)
    );

    // The first cycle of every slot keeps all anodes off to avoid ghosting.
    always_comb begin
        an_d = '1;
        if ((psc_q != '0) && !hide) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if ((idx_q == IDX_W'(k)) && !(bus.blank_lz_i && lz_mask[k])) begin
                    an_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= '1;
            frame_q  <= 1'b0;
        end else begin
            psc_q    <= psc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;

endmodule
